// File: rtl/t_wire_sink.sv
// t_wire_sink: valid/ready sink for the t-module port bundle; buffers beats in a FIFO and
// checks them against k^SEED. Define WIRE_SINK_PARITY_EN to store and check in_par per beat.
module t_wire_sink #(
  parameter int         DEPTH  = 4,
  parameter int         NBEATS = 16,
  parameter logic [8:0] SEED   = 9'h0A5,
  parameter int         CNTW   = 8,
  parameter int         ERRW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8:0]      in_data,
  input  logic            in_par,
  input  logic            drain_en,
  output logic [CNTW-1:0] beat_count,
  output logic [ERRW-1:0] err_count,
  output logic [ERRW-1:0] par_err,
  output logic            done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
`ifdef WIRE_SINK_PARITY_EN
  localparam int EW = 10;
`else
  localparam int EW = 9;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            in_ready_q, in_ready_d;
  logic [CNTW-1:0] beat_count_q, beat_count_d;
  logic [ERRW-1:0] err_count_q, err_count_d;
  logic [EW-1:0]   entry_in;
  logic [EW-1:0]   beat_p0;
  logic            vld_p0;
  logic            full, empty, full_d;
  logic            push, pop, data_bad;

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (&v) ? v : v + ERRW'(1);
  endfunction

  function automatic logic [8:0] exp_beat(input logic [CNTW-1:0] k);
    logic [8:0] k9;
    k9 = 9'(k);
    return k9 ^ SEED;
  endfunction

`ifdef WIRE_SINK_PARITY_EN
  logic [ERRW-1:0] par_err_q, par_err_d;
  logic            par_bad;
  assign entry_in = {in_par, in_data};
  assign par_bad  = ^beat_p0;
  assign par_err  = par_err_q;
`else
  logic unused_par;
  assign unused_par = in_par;
  assign entry_in   = in_data;
  assign par_err    = '0;
`endif

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  // in_ready_q already reflects fullness before any pop this cycle, so a full FIFO never pushes.
  assign push  = in_valid && in_ready_q;
  assign pop   = drain_en && !empty && (state_q != DONE);

  assign data_bad = (beat_p0[8:0] != exp_beat(beat_count_q));

  always_comb begin
    state_d      = state_q;
    beat_count_d = beat_count_q;
    err_count_d  = err_count_q;
`ifdef WIRE_SINK_PARITY_EN
    par_err_d    = par_err_q;
`endif
    wr_ptr_d     = wr_ptr_q + PW'(push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    case (state_q)
      IDLE: begin
        if (push) state_d = RUN;
      end
      RUN: begin
        if (vld_p0) begin
          beat_count_d = beat_count_q + CNTW'(1);
          if (data_bad) err_count_d = sat_inc(err_count_q);
`ifdef WIRE_SINK_PARITY_EN
          if (par_bad) par_err_d = sat_inc(par_err_q);
`endif
          if (beat_count_d == CNTW'(NBEATS)) state_d = DONE;
        end
      end
      default: ;
    endcase
    full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    in_ready_d = !full_d && (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      in_ready_q   <= 1'b0;
      beat_count_q <= '0;
      err_count_q  <= '0;
      vld_p0       <= 1'b0;
`ifdef WIRE_SINK_PARITY_EN
      par_err_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      in_ready_q   <= in_ready_d;
      beat_count_q <= beat_count_d;
      err_count_q  <= err_count_d;
      vld_p0       <= pop;
`ifdef WIRE_SINK_PARITY_EN
      par_err_q    <= par_err_d;
`endif
    end
  end

  // Stage p0: popped beat, compared and counted one cycle after the pop
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= entry_in;
    if (pop)  beat_p0 <= mem_q[rd_ptr_q[AW-1:0]];
  end

  assign in_ready   = in_ready_q;
  assign beat_count = beat_count_q;
  assign err_count  = err_count_q;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_t_wire_sink.sv
// Bench for t_wire_sink: random-gap beat streams, a beat-level reference model feeding a
// scoreboard queue, and a monitor that checks every counter update the sink reports.
module tb_t_wire_sink;

  localparam int         DEPTH  = 4;
  localparam int         NBEATS = 16;
  localparam int         CNTW   = 8;
  localparam int         ERRW   = 2;
  localparam logic [8:0] SEED   = 9'h0A5;
  localparam int         ERRMAX = (1 << ERRW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [8:0]      in_data;
  logic            in_par;
  logic            drain_en;
  logic [CNTW-1:0] beat_count;
  logic [ERRW-1:0] err_count;
  logic [ERRW-1:0] par_err;
  logic            done;

  always #5 clk = ~clk;

  t_wire_sink #(
    .DEPTH (DEPTH),
    .NBEATS(NBEATS),
    .SEED  (SEED),
    .CNTW  (CNTW),
    .ERRW  (ERRW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_par    (in_par),
    .drain_en  (drain_en),
    .beat_count(beat_count),
    .err_count (err_count),
    .par_err   (par_err),
    .done      (done)
  );

  typedef struct {
    int bc;
    int err;
    int par;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   acc_idx = 0;
  int   m_err   = 0;
  int   m_par   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] ref_beat(input int k);
    logic [8:0] k9;
    k9 = 9'(k % 512);
    return k9 ^ SEED;
  endfunction

  // Reference: the n-th accepted beat since reset is checked against n^SEED.
  task automatic model_accept(input logic [8:0] d, input logic p);
    exp_t e;
    if (acc_idx < NBEATS) begin
      if (d != ref_beat(acc_idx)) m_err = (m_err == ERRMAX) ? m_err : m_err + 1;
`ifdef WIRE_SINK_PARITY_EN
      if ((^d) != p) m_par = (m_par == ERRMAX) ? m_par : m_par + 1;
`else
      if (p === 1'bx) m_par = m_par;
`endif
      e.bc  = acc_idx + 1;
      e.err = m_err;
      e.par = m_par;
      sb.push_back(e);
    end
    acc_idx++;
  endtask

  // Entered and left at posedge+1.
  task automatic send_beat(input logic [8:0] d, input logic p);
    logic rdy;
    int   waited;
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    waited   = 0;
    rdy      = 1'b0;
    while (!rdy && waited < 200) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (rdy) model_accept(d, p);
    else chk("accept_timeout", 0, 1);
    if ($urandom_range(3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0 clean, 1 flip bit0 of beats 3 and 7, 2 random bad bit on six beats,
  // 3 wrong parity on beat 2 with random drain_en
  task automatic run_stream(input int start, input int n, input int mode);
    logic [8:0] d;
    logic       p;
    for (int i = start; i < start + n; i++) begin
      d = ref_beat(i);
      if (mode == 1 && (i == 3 || i == 7)) d[0] = ~d[0];
      if (mode == 2 && (i % 2 == 0) && i < 12) d = d ^ (9'd1 << $urandom_range(8));
      p = ^d;
      if (mode == 3) begin
        if (i == 2) p = ~p;
        drain_en = 1'($urandom_range(1));
      end
      send_beat(d, p);
    end
  endtask

  task automatic wait_count(input int target);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk);
      if (int'(beat_count) == target) hit = 1'b1;
    end
    if (!hit) chk("beat_count_timeout", int'(beat_count), target);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    wait_count(NBEATS);
    @(negedge clk);
    chk("done", int'(done), 1);
    chk("beat_count_at_done", int'(beat_count), NBEATS);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    drain_en = 1'b0;
    sb.delete();
    acc_idx  = 0;
    m_err    = 0;
    m_par    = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_beat_count", int'(beat_count), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_par_err", int'(par_err), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("in_ready_after_rst", int'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_par   = 1'b0;
    drain_en = 1'b0;

    fork
      begin : monitor
        int   prev_bc;
        exp_t e;
        prev_bc = 0;
        forever begin
          @(negedge clk);
          if (!rst && int'(beat_count) != prev_bc) begin
            if (sb.size() == 0) begin
              chk("unexpected_count_update", int'(beat_count), prev_bc);
            end else begin
              e = sb.pop_front();
              chk("sb_beat_count", int'(beat_count), e.bc);
              chk("sb_err_count", int'(err_count), e.err);
              chk("sb_par_err", int'(par_err), e.par);
              chk("sb_done", int'(done), (e.bc == NBEATS) ? 1 : 0);
            end
          end
          prev_bc = int'(beat_count);
        end
      end
    join_none

    // clean stream, continuous drain
    do_reset();
    drain_en = 1'b1;
    run_stream(0, NBEATS, 0);
    wait_done();
    @(negedge clk);
    chk("t1_err_count", int'(err_count), 0);
    chk("t1_in_ready_in_done", int'(in_ready), 0);
    @(posedge clk);
    #1;

    // backpressure: fill the FIFO, one drain cycle reopens it
    do_reset();
    run_stream(0, DEPTH, 0);
    @(negedge clk);
    chk("t2_ready_when_full", int'(in_ready), 0);
    chk("t2_no_pop_without_drain", int'(beat_count), 0);
    @(posedge clk);
    #1;
    drain_en = 1'b1;
    @(posedge clk);
    #1;
    drain_en = 1'b0;
    @(negedge clk);
    chk("t2_ready_after_one_pop", int'(in_ready), 1);
    @(posedge clk);
    #1;
    run_stream(DEPTH, 1, 0);
    drain_en = 1'b1;
    run_stream(DEPTH + 1, NBEATS - DEPTH - 1, 0);
    wait_done();
    chk("t2_err_count", int'(err_count), 0);

    // two corrupted beats
    do_reset();
    drain_en = 1'b1;
    run_stream(0, NBEATS, 1);
    wait_done();
    chk("t3_err_count", int'(err_count), 2);

    // six bad beats saturate a 2-bit error counter
    do_reset();
    drain_en = 1'b1;
    run_stream(0, NBEATS, 2);
    wait_done();
    chk("t4_err_saturated", int'(err_count), ERRMAX);

    // reset mid-burst with beats still buffered
    do_reset();
    drain_en = 1'b1;
    run_stream(0, 6, 0);
    wait_count(6);
    drain_en = 1'b0;
    run_stream(6, 2, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_count_before_rst", int'(beat_count), 6);
    @(posedge clk);
    #1;
    do_reset();
    drain_en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t5_fifo_empty_after_rst", int'(beat_count), 0);
    @(posedge clk);
    #1;
    run_stream(0, NBEATS, 0);
    wait_done();
    chk("t5_err_count", int'(err_count), 0);

    // wrong parity on beat 2, random drain pattern
    do_reset();
    run_stream(0, NBEATS, 3);
    drain_en = 1'b1;
    wait_done();
    chk("t6_err_count", int'(err_count), 0);
`ifdef WIRE_SINK_PARITY_EN
    chk("t6_par_err", int'(par_err), 1);
`else
    chk("t6_par_err", int'(par_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
